// File: rtl/paddle_position_mapper.sv
// ---------------------------------------------------------------------------
// paddle_position_mapper
//
// Converts a filtered paddle reading into the top line of the paddle on
// screen. It tracks the smallest and largest reading seen so far as its
// calibration. Each accepted sample is scaled into 0..(v_active-PADDLE_H)
// with a multiply followed by a sequential restoring divide. The result moves
// the target only when it differs from the current target by at least HYST
// lines. The visible position copies the target only on newframe, so the
// paddle never moves part-way through a frame.
//
// Optional build macro:
//   PADDLE_MAP_INVERT_EN  - mirror the mapped value (range - q) for
//                           reversed pot wiring; timing is unchanged.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   in              filtered paddle sample (IN_W bits)
//   in_latch        one-cycle strobe, in is valid; ignored while busy
//   v_active        visible lines of the current video standard
//   newframe        one-cycle frame-start pulse; updates position
//   position        paddle top line presented to the game
//   position_valid  high once a first target has been committed
//   busy            a sample is being processed
//   cal_min         smallest sample seen since reset
//   cal_max         largest sample seen since reset
//
// State table:
//   state  | meaning
//   IDLE   | waiting for in_latch; updates calibration on accept
//   MULT   | latch range, pick centre path or form numerator
//   DIV    | restoring divide num/span, one quotient bit per cycle
//   HYST   | hysteresis compare and target commit
// ---------------------------------------------------------------------------
module paddle_position_mapper #(
    parameter int IN_W     = 8,
    parameter int POS_W    = 9,
    parameter int PADDLE_H = 32,
    parameter int HYST     = 2,
    parameter int MIN_SPAN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in,
    input  logic             in_latch,
    input  logic [POS_W-1:0] v_active,
    input  logic             newframe,
    output logic [POS_W-1:0] position,
    output logic             position_valid,
    output logic             busy,
    output logic [IN_W-1:0]  cal_min,
    output logic [IN_W-1:0]  cal_max
);

    // The numerator (sample - cal_min) * range needs IN_W + POS_W bits.
    localparam int NUM_W = IN_W + POS_W;
    localparam int CNT_W = $clog2(NUM_W);

    localparam logic [31:0]      PADDLE_H_U = 32'(PADDLE_H);
    localparam logic [31:0]      MIN_SPAN_U = 32'(MIN_SPAN);
    localparam logic [POS_W-1:0] HYST_W     = POS_W'(HYST);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_HYST = 2'd3
    } state_t;

    state_t state, state_next;

    logic [IN_W-1:0]  sample_q;
    logic [POS_W-1:0] range_q;
    logic [IN_W-1:0]  span_q;
    logic [NUM_W-1:0] num_q;
    logic [IN_W-1:0]  rem_q;
    logic [NUM_W-2:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [POS_W-1:0] q_q;
    logic [POS_W-1:0] target_q;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [31:0]      v_active_ext;
    logic [POS_W-1:0] range_now;
    logic [IN_W-1:0]  span_now;
    logic [IN_W-1:0]  offset_now;
    logic [NUM_W-1:0] product_now;
    logic             span_small;

    assign v_active_ext = 32'(v_active);
    assign range_now    = (v_active_ext > PADDLE_H_U)
                          ? POS_W'(v_active_ext - PADDLE_H_U) : '0;
    assign span_now     = cal_max - cal_min;
    assign offset_now   = sample_q - cal_min;
    assign product_now  = NUM_W'(offset_now) * NUM_W'(range_now);
    assign span_small   = (32'(span_now) < MIN_SPAN_U);

    // One restoring-divide step: bring down the next numerator bit and
    // subtract the divisor if it fits. rem_q < span_q always holds, so the
    // trial fits in IN_W+1 bits and the new remainder fits back in IN_W.
    logic [IN_W:0]    trial;
    logic             q_bit;
    logic [IN_W:0]    trial_sub;
    logic [IN_W-1:0]  rem_next;
    logic [NUM_W-1:0] quo_next;
    logic [POS_W-1:0] quo_clamped;

    assign trial       = {rem_q, num_q[NUM_W-1]};
    assign q_bit       = (trial >= {1'b0, span_q});
    assign trial_sub   = trial - {1'b0, span_q};
    assign rem_next    = q_bit ? trial_sub[IN_W-1:0] : trial[IN_W-1:0];
    assign quo_next    = {quo_q, q_bit};
    // The quotient cannot exceed range in practice; the clamp is defensive.
    assign quo_clamped = (quo_next > NUM_W'(range_q)) ? range_q : quo_next[POS_W-1:0];

    // Hysteresis compare on the (optionally mirrored) committed value.
    logic [POS_W-1:0] q_eff;
    logic [POS_W-1:0] q_delta;
    logic             commit;

`ifdef PADDLE_MAP_INVERT_EN
    assign q_eff = range_q - q_q;
`else
    assign q_eff = q_q;
`endif

    assign q_delta = (q_eff >= target_q) ? (q_eff - target_q) : (target_q - q_eff);
    assign commit  = (state == S_HYST) && (!position_valid || (q_delta >= HYST_W));

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (in_latch) begin
                    state_next = S_MULT;
                end
            end
            S_MULT: begin
                state_next = span_small ? S_HYST : S_DIV;
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_next = S_HYST;
                end
            end
            S_HYST: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q       <= '0;
            cal_min        <= '1;
            cal_max        <= '0;
            range_q        <= '0;
            span_q         <= '0;
            num_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            cnt_q          <= '0;
            q_q            <= '0;
            target_q       <= '0;
            position       <= '0;
            position_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_latch) begin
                        sample_q <= in;
                        if (in < cal_min) cal_min <= in;
                        if (in > cal_max) cal_max <= in;
                    end
                end
                S_MULT: begin
                    range_q <= range_now;
                    span_q  <= span_now;
                    rem_q   <= '0;
                    quo_q   <= '0;
                    cnt_q   <= CNT_LAST;
                    if (span_small) begin
                        // Too little travel seen to trust the scaling: centre.
                        q_q   <= range_now >> 1;
                        num_q <= '0;
                    end else begin
                        num_q <= product_now;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_next;
                    num_q <= num_q << 1;
                    quo_q <= quo_next[NUM_W-2:0];
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        q_q <= quo_clamped;
                    end
                end
                S_HYST: begin
                    if (commit) begin
                        target_q       <= q_eff;
                        position_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // The frame update reads the pre-commit target when both coincide.
            if (newframe) begin
                position <= (target_q > range_now) ? range_now : target_q;
            end
        end
    end

endmodule

// File: tb/tb_paddle_position_mapper.sv
module tb_paddle_position_mapper;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_val;
    logic       in_latch;
    logic [8:0] v_active;
    logic       newframe;
    logic [8:0] position;
    logic       position_valid;
    logic       busy;
    logic [7:0] cal_min;
    logic [7:0] cal_max;

    int checks = 0;
    int errors = 0;
    int n;

    paddle_position_mapper dut (
        .clk            (clk),
        .reset          (reset),
        .in             (in_val),
        .in_latch       (in_latch),
        .v_active       (v_active),
        .newframe       (newframe),
        .position       (position),
        .position_valid (position_valid),
        .busy           (busy),
        .cal_min        (cal_min),
        .cal_max        (cal_max)
    );

    always #5 clk = ~clk;

    // Expected committed value for a scaled q with range 224.
    function automatic int m(input int q);
`ifdef PADDLE_MAP_INVERT_EN
        return 224 - q;
`else
        return q;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
    endtask

    // Accept one sample, then count busy cycles (bounded) until idle.
    task automatic latch(input int v, input int exp_busy, input string tag);
        int cnt;
        in_val   = 8'(v);
        in_latch = 1'b1;
        tick();
        in_latch = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk(tag, cnt, exp_busy);
    endtask

    initial begin
        reset    = 1'b1;
        in_val   = '0;
        in_latch = 1'b0;
        newframe = 1'b0;
        v_active = 9'd256;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_position", position, 0);
        chk("rst_valid", position_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cal_min", cal_min, 255);
        chk("rst_cal_max", cal_max, 0);

        frame();
        chk("pre_commit_pos", position, 0);
        chk("pre_commit_valid", position_valid, 0);

        // Centre path: span 0.
        latch(100, 2, "busy_centre");
        chk("cal_min_100", cal_min, 100);
        chk("cal_max_100", cal_max, 100);
        chk("valid_after_commit", position_valid, 1);
        chk("pos_waits_frame", position, 0);
        frame();
        chk("pos_centre", position, 112);

        // Full-scale divide.
        latch(50, 19, "busy_div_50");
        latch(250, 19, "busy_div_250");
        chk("cal_min_50", cal_min, 50);
        chk("cal_max_250", cal_max, 250);
        frame();
        chk("pos_top", position, m(224));
        latch(50, 19, "busy_div_50b");
        frame();
        chk("pos_bottom", position, m(0));

        // Hysteresis.
        latch(150, 19, "busy_150");
        frame();
        chk("pos_150", position, m(112));
        latch(151, 19, "busy_151");
        frame();
        chk("pos_151_hold", position, m(112));
        latch(152, 19, "busy_152");
        frame();
        chk("pos_152_move", position, m(114));

        // Dropped latch at T+5, accepted latch at T+20.
        in_val   = 8'd250;
        in_latch = 1'b1;
        tick();
        in_latch = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 4) begin
                in_val   = 8'd20;
                in_latch = 1'b1;
            end else begin
                in_latch = 1'b0;
            end
            n++;
            tick();
        end
        in_latch = 1'b0;
        chk("busy_window_drop", n, 19);
        chk("dropped_cal_min", cal_min, 50);
        in_val   = 8'd255;
        in_latch = 1'b1;
        tick();
        in_latch = 1'b0;
        chk("accept_t20_busy", busy, 1);
        chk("accept_t20_cal_max", cal_max, 255);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_after_t20", n, 19);
        frame();
        chk("pos_224_again", position, m(224));

        // Standard switch without a new latch.
        v_active = 9'd200;
        frame();
        chk("pos_vactive_200", position, (m(224) > 168) ? 168 : m(224));
        v_active = 9'd32;
        frame();
        chk("pos_range_zero", position, 0);
        v_active = 9'd256;

        // Reset during DIV.
        in_val   = 8'd100;
        in_latch = 1'b1;
        tick();
        in_latch = 1'b0;
        repeat (5) tick();
        chk("busy_in_div", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_position", position, 0);
        chk("mid_rst_valid", position_valid, 0);
        chk("mid_rst_cal_min", cal_min, 255);
        chk("mid_rst_cal_max", cal_max, 0);
        reset = 1'b0;
        repeat (25) tick();
        chk("post_rst_busy", busy, 0);
        frame();
        chk("post_rst_pos", position, 0);
        chk("post_rst_valid", position_valid, 0);

        // Normal operation resumes after reset.
        latch(200, 2, "busy_centre_again");
        frame();
        chk("pos_centre_again", position, 112);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_position_mapper.md
Name: paddle_position_mapper

Overview:
Sits between the paddle filter stage (window_avg output, 8-bit, with latch strobe) and pong_game. It auto-calibrates the observed min/max paddle reading and scales it to a paddle Y position in 0..(v_active-PADDLE_H), with hysteresis. A sequential restoring divider does the scaling. The output updates only on newframe, so a paddle never tears mid-frame across PAL/NTSC/SECAM line counts.

Parameters:
IN_W, 8, width of filtered paddle sample
POS_W, 9, width of position / v_active
PADDLE_H, 32, paddle height in lines subtracted from v_active
HYST, 2, minimum |new-old| in lines required to move the target
MIN_SPAN, 16, calibrated span below which output is centred (must be >=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in  in  IN_W  filtered paddle value
in_latch  in  1  one-cycle strobe, in valid
v_active  in  POS_W  visible lines of current standard
newframe  in  1  one-cycle frame-start pulse
position  out  POS_W  paddle top line for pong_game
position_valid  out  1  high once first target committed
busy  out  1  computation in flight; in_latch ignored
cal_min  out  IN_W  smallest sample seen
cal_max  out  IN_W  largest sample seen

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high. Reset values: position=0, position_valid=0, busy=0, cal_min=all-ones (255), cal_max=0, target=0, FSM=IDLE. Reset mid-operation discards the in-flight result.
- FSM states: IDLE, MULT, DIV, HYST.
- IDLE, in_latch at cycle T:
  - sample_q<=in; cal_min<=min(cal_min,in); cal_max<=max(cal_max,in).
  - Go to MULT.
- MULT (T+1):
  - range = v_active>PADDLE_H ? v_active-PADDLE_H : 0. Latch range.
  - span = cal_max-cal_min.
  - If span<MIN_SPAN: q=range>>1; go to HYST (T+2).
  - Else: num = (sample_q-cal_min)*range, 17-bit unsigned; go to DIV.
- DIV (T+2..T+18): restoring division num/span, one quotient bit per cycle, 17 cycles, MSB first. q = min(quotient, range).
- HYST (T+19, or T+2 on the centre path):
  - If position_valid==0, or |q-target|>=HYST: target<=q and position_valid<=1.
  - Else target unchanged.
  - Go to IDLE.
- busy = (state!=IDLE). Divide path: busy high T+1..T+19. Centre path: busy high T+1..T+2.
- in_latch while busy is dropped, with no queueing. The next accepted latch is at T+20 or later.
- Frame update: on newframe, position<=min(target, range_now), where range_now is computed from the current v_active. If newframe and the HYST commit fall in the same cycle, position takes the pre-commit target.
- Before the first commit, newframe loads 0 and position_valid stays 0.
- Arithmetic: all unsigned, with no overflow. sample_q-cal_min <= span, so quotient <= range; the clamp is defensive.
- PADDLE_H >= v_active gives range 0, so position is 0.

Optional Feature:
PADDLE_MAP_INVERT_EN.
- Defined: committed q is replaced by (range - q) before the hysteresis compare. A high resistance then moves the paddle upward, which suits reversed pot wiring.
- Undefined: no inversion; q is used directly.
- Latency and busy timing are identical in both builds.

Test Plan:
- Reset, v_active=256, latch in=100 -> span 0 takes the centre path, target=112, busy high 2 cycles; next newframe gives position=112, position_valid=1.
- Latch 50 then 250 (cal 50..250, range 224) -> target=224 on the newframe after T+19; then latch 50 -> position 0 after the next newframe.
- Cal 50..250, target 112 (sample 150); latch 151 -> q=113, target stays 112; latch 152 -> q=114, target=114.
- in_latch at T and T+5 -> second dropped; busy high exactly T+1..T+19; latch at T+20 accepted (cal_max updates at T+21).
- Target 224, switch v_active to 200 -> next newframe position=168 with no new latch.
- Reset asserted during DIV -> next cycle busy=0, position=0, position_valid=0, cal_min=255, cal_max=0; a later newframe keeps position 0.
- (PADDLE_MAP_INVERT_EN defined) cal 50..250, latch 250 -> position 0.
